// File: rtl/shift_seq.sv
// Multi-cycle shifter/rotator: one bit position per clock, driven by a down-counter
// with a start/busy/done handshake.
//
// state  | meaning
// IDLE   | waiting for start, y holds last result
// RUN    | one shift step per edge, count decrements to zero
// DONE   | one-cycle result-valid pulse, may recapture on start
module shift_seq #(
  parameter int WIDTH = 8,
  parameter int AMT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             dir,
  input  logic [1:0]       mode,
  input  logic [AMT_W-1:0] amt,
  input  logic [WIDTH-1:0] a,
  output logic [WIDTH-1:0] y,
  output logic             busy,
  output logic             done
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       r_state;
  logic [WIDTH-1:0] r_y;
  logic [AMT_W-1:0] r_cnt;
  logic             r_dir;
  logic [1:0]       r_mode;

  logic [WIDTH-1:0] w_step;
  logic [AMT_W-1:0] w_load;
  logic             w_rot;
  logic             w_arith;

  assign w_rot   = (r_mode == 2'b10);
  assign w_arith = (r_mode == 2'b01);

  // Reserved mode 11 falls through to the logical fill.
  always_comb begin
    w_step = r_y;
    if (!r_dir) begin
      w_step = {r_y[WIDTH-2:0], (w_rot ? r_y[WIDTH-1] : 1'b0)};
    end else begin
      w_step = {(w_rot ? r_y[0] : (w_arith ? r_y[WIDTH-1] : 1'b0)), r_y[WIDTH-1:1]};
    end
  end

  // Shifts saturate at WIDTH steps; rotates run the full requested amount.
  always_comb begin
    w_load = amt;
    if (mode != 2'b10 && int'(amt) > WIDTH) begin
      w_load = AMT_W'(WIDTH);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_y     <= '0;
      r_cnt   <= '0;
      r_dir   <= 1'b0;
      r_mode  <= 2'b00;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (start) begin
            r_y     <= a;
            r_dir   <= dir;
            r_mode  <= mode;
            r_cnt   <= w_load;
            r_state <= (w_load == '0) ? S_DONE : S_RUN;
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_RUN: begin
          r_y   <= w_step;
          r_cnt <= r_cnt - AMT_W'(1);
          if (r_cnt == AMT_W'(1)) begin
            r_state <= S_DONE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign y    = r_y;
  assign busy = (r_state == S_RUN);
  assign done = (r_state == S_DONE);

endmodule

// File: tb/tb_shift_seq.sv
// Self-checking bench for shift_seq: directed cases plus randomized operations
// compared against an arithmetic reference model.
module tb_shift_seq;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       dir = 1'b0;
  logic [1:0] mode = 2'b00;
  logic [3:0] amt = '0;
  logic [7:0] a = '0;
  logic [7:0] y;
  logic       busy;
  logic       done;

  int tests = 0;
  int fails = 0;

  shift_seq #(.WIDTH(8), .AMT_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .dir(dir), .mode(mode),
    .amt(amt), .a(a), .y(y), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic void model(input logic [7:0] ai, input logic di, input logic [1:0] mi,
                                input logic [3:0] ami, output logic [7:0] yo, output int n);
    logic [15:0] dbl;
    int k;
    if (mi == 2'b10) begin
      n = int'(ami);
      k = n % 8;
      dbl = {ai, ai};
      if (!di) begin
        dbl = dbl << k;
        yo = dbl[15:8];
      end else begin
        dbl = dbl >> k;
        yo = dbl[7:0];
      end
    end else begin
      n = (int'(ami) > 8) ? 8 : int'(ami);
      if (!di)               yo = ai << n;
      else if (mi == 2'b01)  yo = 8'($signed(ai) >>> n);
      else                   yo = ai >> n;
    end
  endfunction

  // Entered and left at #1 after a rising edge; leaves in the DONE cycle.
  task automatic do_op(input logic [7:0] ai, input logic di, input logic [1:0] mi,
                       input logic [3:0] ami, input bit keep_start, input bit disturb,
                       output logic [7:0] yres);
    logic [7:0] ye;
    int n, cyc, bcnt;
    model(ai, di, mi, ami, ye, n);
    a = ai; dir = di; mode = mi; amt = ami; start = 1'b1;
    @(posedge clk); #1;
    chk("capture_y", y, ai);
    chk("capture_busy", busy, (n > 0));
    if (!keep_start) start = 1'b0;
    cyc = 0;
    bcnt = busy;
    while (!done && cyc < 40) begin
      if (disturb && cyc == 1) begin
        start = 1'b1; a = ~ai; dir = ~di; mode = 2'b10; amt = 4'd1;
      end
      if (disturb && cyc == 2) start = 1'b0;
      @(posedge clk); #1;
      cyc++;
      bcnt += busy;
    end
    chk("done_seen", done, 1'b1);
    chk("latency", cyc, n);
    chk("busy_cycles", bcnt, n);
    chk("result", y, ye);
    yres = y;
  endtask

  logic [7:0] r, ra, yhold;
  logic       rd;
  logic [1:0] rm;
  logic [3:0] rt;

  initial begin
    #2;
    chk("rst_y", y, 8'h00);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    do_op(8'b00110011, 1'b0, 2'b00, 4'd2, 0, 0, r);  chk("lsl2", r, 8'b11001100);
    @(posedge clk); #1;
    chk("idle_done_low", done, 1'b0);
    chk("idle_hold_y", y, 8'b11001100);
    do_op(8'b10110011, 1'b1, 2'b01, 4'd3, 0, 0, r);  chk("asr3", r, 8'b11110110);
    do_op(8'b10110011, 1'b1, 2'b10, 4'd3, 0, 0, r);  chk("ror3", r, 8'b01110110);
    do_op(8'b10110011, 1'b0, 2'b10, 4'd9, 0, 0, r);  chk("rol9", r, 8'b01100111);
    do_op(8'h5A, 1'b1, 2'b00, 4'd0, 0, 0, r);        chk("amt0", r, 8'h5A);
    do_op(8'hFF, 1'b0, 2'b00, 4'd12, 0, 0, r);       chk("lsl12_sat", r, 8'h00);
    do_op(8'b10110011, 1'b1, 2'b11, 4'd2, 0, 0, r);  chk("mode11_lsr", r, 8'b00101100);
    do_op(8'b10010110, 1'b0, 2'b00, 4'd5, 0, 1, r);  chk("start_in_run", r, 8'b11000000);
    do_op(8'b10000001, 1'b1, 2'b01, 4'd2, 1, 0, r);  chk("b2b_first", r, 8'b11100000);
    do_op(8'b00000011, 1'b0, 2'b10, 4'd1, 0, 0, r);  chk("b2b_second", r, 8'b00000110);

    // Asynchronous reset mid-run, checked before any further clock edge.
    a = 8'hC3; dir = 1'b0; mode = 2'b00; amt = 4'd6; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk("midrun_rst_y", y, 8'h00);
    chk("midrun_rst_busy", busy, 1'b0);
    chk("midrun_rst_done", done, 1'b0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    do_op(8'h81, 1'b1, 2'b10, 4'd4, 0, 0, r);        chk("after_rst", r, 8'h18);

    for (int i = 0; i < 40; i++) begin
      ra = 8'($urandom);
      rd = 1'($urandom);
      rm = 2'($urandom);
      rt = 4'($urandom);
      do_op(ra, rd, rm, rt, bit'($urandom_range(0, 1)), 0, r);
      if ($urandom_range(0, 3) == 0) begin
        yhold = y;
        start = 1'b0;
        @(posedge clk); #1;
        chk("rand_idle_y", y, yhold);
        chk("rand_idle_busy", busy, 1'b0);
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
